// File: rtl/slow_to_fast_mux.sv
// Purpose: synchronises CHANNELS async strobe/data pairs into fast_clk and merges them round-robin into one FWFT FIFO.
// Latency: strobe rise set up before edge E0 -> pend_v at E0+SYNC_STAGES, FIFO write (out_valid) at E0+SYNC_STAGES+1.
// Backpressure: out_ready low holds the head; a full FIFO stalls grants; a new word on a still-pending channel is dropped and flagged.
module slow_to_fast_mux #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      fast_clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       async_strobe,
    input  logic [CHANNELS*WIDTH-1:0] async_data,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [CHANNELS-1:0]       overflow,
    input  logic                      clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int EW = CW + WIDTH;

    // Strobe synchroniser and edge detection
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] hist_q;
    logic [CHANNELS-1:0] sync_last;
    logic [CHANNELS-1:0] ev;

    // Per-channel pending word
    logic [CHANNELS-1:0] pend_v_q, pend_v_d;
    logic [WIDTH-1:0]    pend_data_q [CHANNELS];
    logic [WIDTH-1:0]    pend_data_d [CHANNELS];

    // Arbiter
    logic [CW-1:0]       rr_q, rr_d;
    logic                gnt_vld;
    logic [CW-1:0]       gnt_idx;
    logic [CHANNELS-1:0] gnt_oh;

    // Overflow flags
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] drop;

    // FIFO
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]       count_q, count_d;
    logic [EW-1:0]       head_q, head_d;
    logic [EW-1:0]       wr_ent;
    logic                push;
    logic                pop;
    logic                can_push;

    // Channel index 'off' places after 'base', wrapping at CHANNELS
    function automatic logic [CW-1:0] rr_pick(input logic [CW-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % CHANNELS;
        return CW'(sum);
    endfunction

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign ev        = sync_last & ~hist_q;

    // Synchroniser chain plus one-cycle history of its output; a strobe high at reset release reads as a rise
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= async_strobe;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_last;
        end
    end

    // FIFO handshake terms; a full FIFO still accepts when the head leaves this cycle
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign can_push  = (count_q != NW'(DEPTH)) || pop;
    assign push      = gnt_vld;

    // Round-robin pick: search starts one past the last granted channel
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!gnt_vld && can_push && pend_v_q[rr_pick(rr_q, i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_pick(rr_q, i);
            end
        end
    end

    // One-hot view of the grant for per-channel bookkeeping
    always_comb begin
        gnt_oh = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            gnt_oh[c] = gnt_vld && (gnt_idx == CW'(c));
        end
    end

    assign rr_d   = gnt_vld ? gnt_idx : rr_q;
    assign wr_ent = {gnt_idx, pend_data_q[gnt_idx]};

    // Pending slot: a new edge loads when the slot is free or being granted now, otherwise it is dropped
    always_comb begin
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        drop        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ev[c] && (!pend_v_q[c] || gnt_oh[c])) begin
                pend_v_d[c]    = 1'b1;
                pend_data_d[c] = async_data[c*WIDTH +: WIDTH];
            end else if (gnt_oh[c]) begin
                pend_v_d[c] = 1'b0;
            end
            drop[c] = ev[c] & pend_v_q[c] & ~gnt_oh[c];
        end
    end

    // Sticky drop flags; a drop in the same cycle as a clear survives
    always_comb begin
        ovf_d = (clear_ovf ? '0 : ovf_q) | drop;
    end

    // Pending slots, arbiter pointer and overflow registers
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pend_data_q[c] <= '0;
            end
            rr_q  <= '0;
            ovf_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            rr_q        <= rr_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO next state; the head register reloads from the slot that becomes oldest after this cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        // Entry being written becomes the head when nothing older remains
        if (push && (count_q == NW'(pop))) begin
            head_d = wr_ent;
        end else if (pop) begin
            head_d = mem_q[rd_ptr_q + AW'(1)];
        end
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge fast_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    assign out_data   = head_q[WIDTH-1:0];
    assign out_chan   = head_q[EW-1:WIDTH];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule
